// File: rtl/bus_ram_responder_pkg.sv
// ---------------------------------------------------------------------------
// bus_ram_responder_pkg
//   Shared CPU defines for the bus RAM responder: FSM state encoding and
//   the wait-state limits.
// ---------------------------------------------------------------------------
package bus_ram_responder_pkg;

    // Largest supported WAIT_STATES value; the wait counter is sized to hold it.
    localparam int unsigned WAIT_STATES_MAX = 15;
    localparam int unsigned WCNT_W          = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_ACCESS  = 2'd2,
        ST_RESPOND = 2'd3
    } state_e;

endpackage

// File: rtl/bus_ram_responder_bram.sv
// ---------------------------------------------------------------------------
// bus_ram_responder_bram
//   Single-port synchronous RAM, 32-bit wide, 2^SIZE words deep. Read data
//   appears one cycle after an enabled access (read-before-write) and holds
//   until the next enabled access. Contents are never reset.
//
// Ports
//   i_clock  : clock
//   i_en     : access enable (read, or write when i_we=1)
//   i_we     : write enable, qualified by i_en
//   i_addr   : word address
//   i_wdata  : write data
//   o_rdata  : registered read data
// ---------------------------------------------------------------------------
module bus_ram_responder_bram #(
    parameter int unsigned SIZE = 12
) (
    input  logic            i_clock,
    input  logic            i_en,
    input  logic            i_we,
    input  logic [SIZE-1:0] i_addr,
    input  logic [31:0]     i_wdata,
    output logic [31:0]     o_rdata
);

    logic [31:0] mem_q [0:(2**SIZE)-1];
    logic [31:0] rdata_q;

    always_ff @(posedge i_clock) begin
        if (i_en) begin
            if (i_we) begin
                mem_q[i_addr] <= i_wdata;
            end
            rdata_q <= mem_q[i_addr];
        end
    end

    assign o_rdata = rdata_q;

endmodule

// File: rtl/bus_ram_responder.sv
// ---------------------------------------------------------------------------
// bus_ram_responder
//   Bus slave that serves word reads/writes from an internal RAM with a
//   programmable number of wait states. Each transfer walks
//   IDLE -> [WAIT] -> ACCESS -> RESPOND, pulsing o_bus_ready for exactly one
//   cycle in RESPOND.
//
// Parameters
//   SIZE        : log2 of memory depth in 32-bit words
//   WAIT_STATES : extra wait cycles before each access (0..15)
//
// Ports
//   i_clock       : clock, rising edge
//   i_reset       : asynchronous reset, active low
//   i_bus_request : transfer request, held until ready
//   i_bus_rw      : 1 = write, 0 = read
//   i_bus_address : byte address; bits [SIZE+1:2] select the word
//   i_bus_wdata   : write data
//   o_bus_rdata   : read data, valid with ready, held until the next read
//   o_bus_ready   : one-cycle completion strobe
// ---------------------------------------------------------------------------
module bus_ram_responder
    import bus_ram_responder_pkg::*;
#(
    parameter int unsigned SIZE        = 12,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_bus_request,
    input  logic        i_bus_rw,
    input  logic [31:0] i_bus_address,
    input  logic [31:0] i_bus_wdata,
    output logic [31:0] o_bus_rdata,
    output logic        o_bus_ready
);

    // Values above WAIT_STATES_MAX do not fit the counter and are unsupported.
    localparam logic [WCNT_W-1:0] WS_LOAD = WCNT_W'(WAIT_STATES);

    state_e            state_q;
    logic [SIZE-1:0]   addr_q;
    logic              rw_q;
    logic [31:0]       wdata_q;
    logic [WCNT_W-1:0] wcnt_q;
    logic              ready_q;
    logic [31:0]       rdata_q;

    logic              ram_en;
    logic              ram_we;
    logic [31:0]       ram_rdata;

    // Byte-lane bits and bits above the word index play no part in decoding.
    logic              unused_addr_bits;
    assign unused_addr_bits = ^{i_bus_address[31:SIZE+2], i_bus_address[1:0]};

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            rw_q    <= 1'b0;
            wdata_q <= '0;
            wcnt_q  <= '0;
            ready_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            ready_q <= 1'b0;
            case (state_q)
                // RESPOND doubles as an accept slot so that a request held
                // high runs back-to-back at one transfer per WAIT_STATES+2.
                ST_IDLE, ST_RESPOND: begin
                    if (state_q == ST_RESPOND && !rw_q) begin
                        rdata_q <= ram_rdata;
                    end
                    if (i_bus_request) begin
                        addr_q  <= i_bus_address[SIZE+1:2];
                        rw_q    <= i_bus_rw;
                        wdata_q <= i_bus_wdata;
                        wcnt_q  <= WS_LOAD;
                        state_q <= (WAIT_STATES == 0) ? ST_ACCESS : ST_WAIT;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    wcnt_q <= wcnt_q - 1'b1;
                    if (wcnt_q == WCNT_W'(1)) begin
                        state_q <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    ready_q <= 1'b1;
                    state_q <= ST_RESPOND;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign ram_en = (state_q == ST_ACCESS);
    assign ram_we = ram_en && rw_q;

    bus_ram_responder_bram #(
        .SIZE (SIZE)
    ) u_bram (
        .i_clock (i_clock),
        .i_en    (ram_en),
        .i_we    (ram_we),
        .i_addr  (addr_q),
        .i_wdata (wdata_q),
        .o_rdata (ram_rdata)
    );

    // The RAM output register already holds the read word during RESPOND, so
    // it is forwarded in that cycle; rdata_q keeps it afterwards. Both legs are
    // registers, so nothing reaches the outputs from the bus inputs.
    assign o_bus_rdata = (state_q == ST_RESPOND && !rw_q) ? ram_rdata : rdata_q;
    assign o_bus_ready = ready_q;

endmodule

// File: tb/tb_bus_ram_responder.sv
// ---------------------------------------------------------------------------
// tb_bus_ram_responder
//   Randomized scoreboard bench for bus_ram_responder (SIZE=12, 2 wait
//   states). The driver issues transfers at falling edges and pushes the
//   expected ready edge and read data from a word-array memory model; the
//   monitor checks outputs 1 time unit after every rising edge.
// ---------------------------------------------------------------------------
module tb_bus_ram_responder;

    localparam int unsigned SIZE = 12;
    localparam int unsigned WS   = 2;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        req   = 1'b0;
    logic        rw    = 1'b0;
    logic [31:0] addr  = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        ready;

    always #5 clk = ~clk;

    bus_ram_responder #(
        .SIZE        (SIZE),
        .WAIT_STATES (WS)
    ) dut (
        .i_clock       (clk),
        .i_reset       (rst_n),
        .i_bus_request (req),
        .i_bus_rw      (rw),
        .i_bus_address (addr),
        .i_bus_wdata   (wdata),
        .o_bus_rdata   (rdata),
        .o_bus_ready   (ready)
    );

    typedef struct {
        int          at_edge;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model [0:(2**SIZE)-1];
    logic [31:0] last_rd = '0;   // model's view of the held read data
    logic [31:0] hold    = '0;   // monitor's expected rdata outside ready
    int          edges   = 0;
    int          total   = 0;
    int          bad     = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (edge %0d)", name, act, exp, edges);
        end
    endtask

    // Monitor: ready must appear exactly at the predicted edge with the
    // predicted data; rdata must hold between pulses.
    always @(posedge clk) begin
        exp_t x;
        edges++;
        #1;
        while (sb.size() > 0 && sb[0].at_edge < edges) begin
            total++;
            bad++;
            $display("FAIL missing_ready: no ready at edge %0d, want ready=1", sb[0].at_edge);
            void'(sb.pop_front());
        end
        if (ready) begin
            if (sb.size() == 0 || sb[0].at_edge != edges) begin
                total++;
                bad++;
                $display("FAIL spurious_ready: ready=1 at edge %0d, want 0", edges);
            end else begin
                x = sb.pop_front();
                chk("rdata_on_ready", rdata, x.data);
                hold = x.data;
            end
        end else begin
            chk("rdata_hold", rdata, hold);
        end
    end

    // Issue one transfer starting at the current falling edge; returns at the
    // falling edge of the ready cycle. scr: 0 = inputs stable, 1 = randomize
    // inputs while busy, 2 = move address to 0x20 and drop request at once.
    task automatic xfer(input bit wr, input logic [31:0] a, input logic [31:0] d,
                        input int scr, input bit keep_req);
        int idx;
        idx   = int'(a[SIZE+1:2]);
        req   = 1'b1;
        rw    = wr;
        addr  = a;
        wdata = d;
        if (wr) begin
            model[idx] = d;
        end else begin
            last_rd = model[idx];
        end
        sb.push_back('{edges + int'(WS) + 2, last_rd});
        for (int i = 0; i < int'(WS) + 2; i++) begin
            @(negedge clk);
            if (i < int'(WS) + 1) begin
                if (scr == 1) begin
                    req   = 1'($urandom);
                    rw    = 1'($urandom);
                    addr  = $urandom;
                    wdata = $urandom;
                end else if (scr == 2 && i == 0) begin
                    addr = 32'h20;
                    req  = 1'b0;
                end
            end
        end
        if (!keep_req) req = 1'b0;
    endtask

    task automatic idle(input int n);
        req = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("reset_ready", {31'b0, ready}, 32'h0);
        chk("reset_rdata", rdata, 32'h0);

        // Request already up when reset releases; then read back-to-back.
        rst_n = 1'b1;
        xfer(1'b1, 32'h10, 32'hDEADBEEF, 0, 1'b1);
        xfer(1'b0, 32'h10, 32'h0, 0, 1'b0);
        idle(2);

        // Upper address bits wrap onto word 2.
        xfer(1'b1, 32'h4008, 32'h12345678, 0, 1'b0);
        idle(1);
        xfer(1'b0, 32'h8, 32'h0, 0, 1'b0);
        idle(1);

        // Preload 1..4 and stream four reads with request held high.
        for (int i = 0; i < 4; i++) xfer(1'b1, 32'(i * 4), 32'(i + 1), 0, 1'b1);
        for (int i = 0; i < 4; i++) xfer(1'b0, 32'(i * 4), 32'h0, 0, i < 3);
        idle(1);

        // Address moves to 0x20 and request drops right after latching.
        xfer(1'b1, 32'h20, 32'hCAFEF00D, 0, 1'b0);
        idle(1);
        xfer(1'b0, 32'h10, 32'h0, 2, 1'b0);
        idle(2);
        xfer(1'b1, 32'h0, 32'h0BADF00D, 1, 1'b0);   // inputs churn during a write
        xfer(1'b0, 32'h0, 32'h0, 1, 1'b0);
        idle(1);

        // Reset during WAIT of a write: aborted, no ready, word untouched.
        xfer(1'b1, 32'h30, 32'hA5A5A5A5, 0, 1'b0);
        xfer(1'b0, 32'h30, 32'h0, 0, 1'b0);
        req   = 1'b1;
        rw    = 1'b1;
        addr  = 32'h30;
        wdata = 32'h5A5A5A5A;
        @(negedge clk);
        rst_n   = 1'b0;
        req     = 1'b0;
        last_rd = '0;
        hold    = '0;
        #1;
        chk("abort_ready", {31'b0, ready}, 32'h0);
        chk("abort_rdata", rdata, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        xfer(1'b0, 32'h30, 32'h0, 0, 1'b0);
        idle(1);

        // Randomized traffic over a 16-word window with random upper bits.
        for (int w = 0; w < 16; w++) begin
            xfer(1'b1, ($urandom & 32'hFFFF_C000) | 32'(w << 2), $urandom, 0, 1'($urandom));
        end
        for (int n = 0; n < 300; n++) begin
            int          w;
            logic [31:0] a;
            bit          b2b;
            w   = int'($urandom_range(0, 15));
            a   = ($urandom & 32'hFFFF_C000) | 32'(w << 2) | ($urandom & 32'h3);
            b2b = 1'($urandom);
            xfer(1'($urandom), a, $urandom, int'($urandom_range(0, 1)), b2b);
            if (!b2b) idle(int'($urandom_range(0, 3)));
        end

        idle(10);
        chk("scoreboard_empty", 32'(sb.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bus_ram_responder.md
BUS_RAM_RESPONDER -- requirements
Module: bus_ram_responder

Interface
REQ-001 Parameter SIZE, default 12, SHALL set memory depth to 2^SIZE 32-bit words.
REQ-002 Parameter WAIT_STATES, default 0, range 0..15, SHALL set extra wait cycles inserted before every access.
REQ-003 i_clock  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 i_reset  in  1  SHALL be an asynchronous, active-low reset.
REQ-005 i_bus_request  in  1  SHALL mean the initiator requests a transfer; it is held high until ready.
REQ-006 i_bus_rw  in  1  SHALL select the transfer type: 1 = write, 0 = read.
REQ-007 i_bus_address  in  32  SHALL be the byte address; bits [1:0] are ignored, and bits [SIZE+1:2] select the word.
REQ-008 i_bus_wdata  in  32  SHALL be the write data.
REQ-009 o_bus_rdata  out  32  SHALL be the read data, valid while o_bus_ready is high and held until the next read completes.
REQ-010 o_bus_ready  out  1  SHALL be the completion strobe: exactly one cycle per transfer.

Function
REQ-011 The block SHALL implement the states IDLE, WAIT, ACCESS and RESPOND.
REQ-012 IDLE with i_bus_request=1 at a rising edge SHALL latch address, rw and wdata, load the wait counter with WAIT_STATES, and go to WAIT if WAIT_STATES>0, otherwise to ACCESS.
REQ-013 WAIT SHALL decrement the counter each cycle and go to ACCESS on the edge where the counter is 1.
REQ-014 ACCESS SHALL present the latched word address to the RAM for one cycle, write latched wdata if rw=1, then go to RESPOND.
REQ-015 RESPOND SHALL drive o_bus_ready=1 for one cycle, load o_bus_rdata from RAM output on reads only, and then go to IDLE.
REQ-016 Latency: with the request first sampled high at the end of cycle N, o_bus_ready SHALL be high in cycle N+WAIT_STATES+2.
REQ-017 Address, rw and wdata changes after the latch edge SHALL be ignored until the next transfer.
REQ-018 Request deasserted mid-transfer SHALL NOT abort the transfer; ready still pulses and a write still commits.
REQ-019 Request high in the cycle after the ready pulse SHALL be treated as a new transfer (back-to-back); the maximum throughput is one transfer per WAIT_STATES+2 cycles.
REQ-020 Address bits above SIZE+1 SHALL be ignored, so addresses wrap modulo 2^SIZE words.
REQ-021 A write followed by a read of the same word SHALL return the written data.
REQ-022 On writes, o_bus_rdata SHALL keep its previous value.
REQ-023 The RAM SHALL be written only in the ACCESS state.

Reset
REQ-024 While i_reset=0: state=IDLE, o_bus_ready=0, o_bus_rdata=0, wait counter=0, latched registers=0.
REQ-025 Reset asserted mid-transfer SHALL abort it immediately: no ready pulse, and no write if ACCESS has not yet been clocked.
REQ-026 RAM contents SHALL NOT be cleared by reset.
REQ-027 After reset release, a request held high SHALL be sampled at the first rising edge with i_reset=1.

Structure
REQ-028 The state enum and the WAIT_STATES maximum constant (15) SHALL live in the shared CPU defines package.
REQ-029 The storage SHALL be one sub-module, BRAM: single-port synchronous RAM, 32-bit wide, 2^SIZE deep, one-cycle read latency.
REQ-030 The responder SHALL contain only the FSM, counter and latches, with no combinational path from the inputs to o_bus_ready.

Verification
REQ-031 WAIT_STATES=0: write 0xDEADBEEF to 0x00000010, then read 0x00000010 -> ready in cycle N+2 each time; rdata=0xDEADBEEF.
REQ-032 WAIT_STATES=3: read 0x00000004 -> ready exactly once, in cycle N+5; ready low in all other cycles.
REQ-033 SIZE=12: write 0x12345678 to 0x00004008, then read 0x00000008 -> rdata=0x12345678 (wrap).
REQ-034 Request held high across 4 consecutive reads of 0x0,0x4,0x8,0xC (preloaded 1,2,3,4) -> 4 ready pulses at 2-cycle spacing; rdata=1,2,3,4.
REQ-035 Change address to 0x20 and drop request one cycle after a read of 0x10 is latched -> a single ready pulse; rdata=contents of 0x10.
REQ-036 Assert i_reset=0 during WAIT of a write to 0x30 (WAIT_STATES=2) -> no ready pulse; word 0x30 unchanged; outputs 0 immediately.
